// File: rtl/sadd_pkg.sv
// rtl/sadd_pkg.sv - shared FSM type and configuration check for digit_serial_adder
//
// Contents:
//   sadd_state_t  - controller states IDLE / RUN / DONE
//   sadd_cfg_ok() - constant function; true when DIGIT divides WIDTH and 1 <= DIGIT <= WIDTH
package sadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sadd_state_t;

  function automatic bit sadd_cfg_ok(input int width, input int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// rtl/digit_serial_adder_if.sv - operand/result handshake bundle for digit_serial_adder
//
// Parameter: WIDTH - operand and result width
// Signals:
//   in_valid/in_ready   operand handshake (a, b, cin, sub)
//   out_valid/out_ready result handshake (sum, cout, ovf)
// Modports:
//   master - producer of operands / consumer of results
//   slave  - the adder
interface digit_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/digit_ripple_adder.sv
// rtl/digit_ripple_adder.sv - combinational DIGIT-bit ripple-carry adder
//
// Parameter: DIGIT - digit width
// Ports:
//   a, b  in  DIGIT  digit operands
//   cin   in  1      carry into bit 0
//   s     out DIGIT  digit sum
//   cout  out 1      carry out of the MSB
//   cmsb  out 1      carry into the MSB (for signed overflow)
module digit_ripple_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  // The chain is walked with a scalar carry variable so each full-adder
  // cell sees the carry of the cell below it.
  always_comb begin
    logic c;
    s    = '0;
    cmsb = cin;
    c    = cin;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) cmsb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - digit-serial adder/subtractor with valid/ready handshakes
//
// Parameters: WIDTH (operand width), DIGIT (bits per cycle, divides WIDTH)
// Optional feature macro: SADD_SIGNED_OVF_EN (signed overflow output; ovf tied low otherwise)
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of digit_serial_adder_if:
//          in_valid/in_ready + a, b, cin, sub ; out_valid/out_ready + sum, cout, ovf
module digit_serial_adder
  import sadd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  digit_serial_adder_if.slave   bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (!sadd_cfg_ok(WIDTH, DIGIT)) begin : g_cfg_err
    $error("digit_serial_adder: WIDTH must be a multiple of DIGIT and 1 <= DIGIT <= WIDTH");
  end

  sadd_state_t      state, state_nx;
  logic             in_ready_c, out_valid_c;
  logic             accept, last;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0] d_a, d_b, d_sum;
  logic             d_cout, d_cmsb;

  assign last   = (cnt_q == LAST);
  assign accept = bus.in_valid && in_ready_c;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nx    = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Current digit of the latched operands
  assign d_a = a_q[cnt_q*DIGIT +: DIGIT];
  assign d_b = b_q[cnt_q*DIGIT +: DIGIT];

  digit_ripple_adder #(.DIGIT(DIGIT)) u_digit (
    .a    (d_a),
    .b    (d_b),
    .cin  (carry_q),
    .s    (d_sum),
    .cout (d_cout),
    .cmsb (d_cmsb)
  );

  // Operand latch, carry register, digit counter and result registers.
  // Subtraction is folded into the latch: B is stored inverted and the
  // carry register starts at 1, so RUN only ever adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.sub ? ~bus.b : bus.b;
      carry_q <= bus.sub ? 1'b1 : bus.cin;
      cnt_q   <= '0;
    end else if (state == RUN) begin
      sum_q[cnt_q*DIGIT +: DIGIT] <= d_sum;
      carry_q                     <= d_cout;
      if (last) begin
        cnt_q  <= '0;
        cout_q <= d_cout;
      end else begin
        cnt_q  <= cnt_q + CW'(1);
      end
    end
  end

`ifdef SADD_SIGNED_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    ovf_q <= 1'b0;
    else if (state == RUN && last) ovf_q <= d_cmsb ^ d_cout;
  end

  assign bus.ovf = ovf_q;
`else
  logic unused_cmsb;
  assign unused_cmsb = d_cmsb;
  assign bus.ovf     = 1'b0;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - self-checking bench for digit_serial_adder (16/4, 8/8, 8/1)
module tb_digit_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

`ifdef SADD_SIGNED_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  digit_serial_adder_if #(.WIDTH(16)) if16 ();
  digit_serial_adder_if #(.WIDTH(8))  if8a ();
  digit_serial_adder_if #(.WIDTH(8))  if8b ();

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  digit_serial_adder #(.WIDTH(8),  .DIGIT(8)) u8a (.clk(clk), .rst_n(rst_n), .bus(if8a.slave));
  digit_serial_adder #(.WIDTH(8),  .DIGIT(1)) u8b (.clk(clk), .rst_n(rst_n), .bus(if8b.slave));

  // Reference model: integer arithmetic on the operands' unsigned and signed values.
  function automatic void model(input int w, input longint a, input longint b,
                                input bit cin, input bit sub,
                                output longint s, output bit co, output bit ov);
    longint m, sa, sb, r, sr;
    m  = longint'(1) << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (sub) begin
      r  = a - b;
      co = (a >= b);
      sr = sa - sb;
    end else begin
      r  = a + b + longint'(cin);
      co = (r >= m);
      sr = sa + sb + longint'(cin);
    end
    s  = ((r % m) + m) % m;
    ov = OVF_EN && ((sr < -(m / 2)) || (sr >= m / 2));
  endfunction

  // Accept one operand bundle on the 16-bit DUT and wait for out_valid.
  // Input lines are scrambled right after the accept edge.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input bit cin, input bit sub,
                      output logic [15:0] s, output logic co, output logic ov, output int lat);
    int guard = 0;
    while (!if16.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if16.a = a; if16.b = b; if16.cin = cin; if16.sub = sub;
    if16.in_valid = 1'b1;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    if16.a = 16'($urandom); if16.b = 16'($urandom);
    if16.cin = 1'($urandom); if16.sub = 1'($urandom);
    lat = 0;
    while (!if16.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    s = if16.sum; co = if16.cout; ov = if16.ovf;
  endtask

  task automatic ack16();
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.out_ready = 1'b0;
  endtask

  // Drive the same bundle into both 8-bit DUTs (out_ready held high) and
  // capture each result and latency on its first out_valid.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit cin, input bit sub,
                     output logic [7:0] sa, output logic [7:0] sb,
                     output logic [1:0] fa, output logic [1:0] fb,
                     output int la, output int lb);
    sa = '0; sb = '0; fa = '0; fb = '0; la = -1; lb = -1;
    if8a.a = a; if8a.b = b; if8a.cin = cin; if8a.sub = sub;
    if8b.a = a; if8b.b = b; if8b.cin = cin; if8b.sub = sub;
    if8a.out_ready = 1'b1; if8b.out_ready = 1'b1;
    if8a.in_valid = 1'b1;  if8b.in_valid = 1'b1;
    @(posedge clk); #1;
    if8a.in_valid = 1'b0;  if8b.in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (if8a.out_valid && la < 0) begin la = k; sa = if8a.sum; fa = {if8a.cout, if8a.ovf}; end
      if (if8b.out_valid && lb < 0) begin lb = k; sb = if8b.sum; fb = {if8b.cout, if8b.ovf}; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({if16.in_ready, if16.out_valid, if16.sum, if16.cout, if16.ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset16: got rdy=%b vld=%b sum=%h c=%b o=%b required rdy=1 vld=0 sum=0000 c=0 o=0",
               if16.in_ready, if16.out_valid, if16.sum, if16.cout, if16.ovf);
    end
    checks++;
    if ({if8a.in_ready, if8a.out_valid, if8a.sum, if8b.in_ready, if8b.out_valid, if8b.sum} !==
        {1'b1, 1'b0, 8'h0, 1'b1, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL reset8: got a:%b%b%h b:%b%b%h required a:10 00 b:10 00",
               if8a.in_ready, if8a.out_valid, if8a.sum, if8b.in_ready, if8b.out_valid, if8b.sum);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed16();
    logic [15:0] va[4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h0007};
    logic [15:0] vb[4] = '{16'h0001, 16'h0001, 16'h0007, 16'h0005};
    bit          vc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    bit          vs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es[4] = '{16'h0000, 16'h8000, 16'hFFFE, 16'h0002};
    bit          ec[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit          eo[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] s;
    logic        co, ov;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      op16(va[i], vb[i], vc[i], vs[i], s, co, ov, lat);
      checks++;
      if ({s, co, ov} !== {es[i], ec[i], eo[i] & OVF_EN}) begin
        errors++;
        $display("FAIL directed16[%0d]: got sum=%h c=%b o=%b required sum=%h c=%b o=%b",
                 i, s, co, ov, es[i], ec[i], eo[i] & OVF_EN);
      end
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL latency16[%0d]: got %0d required 4", i, lat);
      end
      ack16();
    end
  endtask

  task automatic test_random16();
    logic [15:0] a, b, s;
    bit          cin, sub, eco, eov;
    logic        co, ov;
    longint      es;
    int          lat;
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      if (i < 4) b = a ^ {16{i[0]}};
      model(16, longint'(a), longint'(b), cin, sub, es, eco, eov);
      op16(a, b, cin, sub, s, co, ov, lat);
      checks++;
      if ({s, co, ov} !== {16'(es), eco, eov} || lat !== 4) begin
        errors++;
        $display("FAIL random16[%0d] %h %s %h cin=%b: got sum=%h c=%b o=%b lat=%0d required sum=%h c=%b o=%b lat=4",
                 i, a, sub ? "-" : "+", b, cin, s, co, ov, lat, 16'(es), eco, eov);
      end
      ack16();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a1, b1, a2, b2, s;
    bit          c1, c2, eco, eov;
    logic        co, ov;
    longint      es;
    int          lat;
    a1 = 16'($urandom); b1 = 16'($urandom); c1 = 1'($urandom);
    a2 = 16'($urandom); b2 = 16'($urandom); c2 = 1'($urandom);
    if16.a = a1; if16.b = b1; if16.cin = c1; if16.sub = 1'b0;
    if16.in_valid = 1'b1; if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.a = a2; if16.b = b2; if16.cin = c2; if16.sub = 1'b1;
    model(16, longint'(a1), longint'(b1), c1, 1'b0, es, eco, eov);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({if16.in_ready, if16.out_valid} !== {k == 5, k == 4}) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got rdy=%b vld=%b required rdy=%b vld=%b",
                 k, if16.in_ready, if16.out_valid, k == 5, k == 4);
      end
      if (k == 4) begin
        checks++;
        if ({if16.sum, if16.cout, if16.ovf} !== {16'(es), eco, eov}) begin
          errors++;
          $display("FAIL b2b_first: got sum=%h c=%b o=%b required sum=%h c=%b o=%b",
                   if16.sum, if16.cout, if16.ovf, 16'(es), eco, eov);
        end
      end
    end
    if16.in_valid = 1'b0; if16.out_ready = 1'b0;
    lat = 0;
    while (!if16.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    s = if16.sum; co = if16.cout; ov = if16.ovf;
    model(16, longint'(a2), longint'(b2), c2, 1'b1, es, eco, eov);
    checks++;
    if ({s, co, ov} !== {16'(es), eco, eov} || lat !== 4) begin
      errors++;
      $display("FAIL b2b_second: got sum=%h c=%b o=%b lat=%0d required sum=%h c=%b o=%b lat=4",
               s, co, ov, lat, 16'(es), eco, eov);
    end
    ack16();
  endtask

  task automatic test_backpressure();
    logic [15:0] a2, b2, s;
    logic        co, ov;
    longint      es;
    bit          eco, eov;
    int          lat, bad;
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
    a2 = 16'($urandom); b2 = 16'($urandom);
    if16.a = a2; if16.b = b2; if16.cin = 1'b1; if16.sub = 1'b0;
    if16.in_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if ({if16.out_valid, if16.in_ready, if16.sum, if16.cout, if16.ovf} !==
          {1'b1, 1'b0, 16'h8000, 1'b0, OVF_EN}) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL backpressure_hold: got %0d unstable cycles required 0", bad);
    end
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.out_ready = 1'b0;
    checks++;
    if ({if16.out_valid, if16.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL backpressure_release: got vld=%b rdy=%b required vld=0 rdy=1",
               if16.out_valid, if16.in_ready);
    end
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    checks++;
    if (if16.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_accept: got rdy=%b required 0", if16.in_ready);
    end
    lat = 0;
    while (!if16.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    model(16, longint'(a2), longint'(b2), 1'b1, 1'b0, es, eco, eov);
    checks++;
    if ({if16.sum, if16.cout, if16.ovf} !== {16'(es), eco, eov} || lat !== 4) begin
      errors++;
      $display("FAIL backpressure_next: got sum=%h c=%b o=%b lat=%0d required sum=%h c=%b o=%b lat=4",
               if16.sum, if16.cout, if16.ovf, lat, 16'(es), eco, eov);
    end
    ack16();
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] s;
    logic        co, ov;
    int          lat, seen;
    if16.a = 16'hFFFF; if16.b = 16'hFFFF; if16.cin = 1'b1; if16.sub = 1'b0;
    if16.in_valid = 1'b1;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if16.in_ready, if16.out_valid, if16.sum, if16.cout, if16.ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_run: got rdy=%b vld=%b sum=%h c=%b o=%b required rdy=1 vld=0 sum=0000 c=0 o=0",
               if16.in_ready, if16.out_valid, if16.sum, if16.cout, if16.ovf);
    end
    #2;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (if16.out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_discard: got %0d out_valid cycles required 0", seen);
    end
    op16(16'h1234, 16'h4321, 1'b0, 1'b0, s, co, ov, lat);
    checks++;
    if ({s, co, ov, lat} !== {16'h5555, 1'b0, 1'b0, 32'sd4}) begin
      errors++;
      $display("FAIL after_reset: got sum=%h c=%b o=%b lat=%0d required sum=5555 c=0 o=0 lat=4",
               s, co, ov, lat);
    end
    ack16();
  endtask

  task automatic test_width8();
    logic [7:0] a, b, sa, sb;
    logic [1:0] fa, fb;
    int         la, lb;
    bit         cin, sub, eco, eov;
    longint     es;
    op8(8'hC8, 8'h64, 1'b0, 1'b0, sa, sb, fa, fb, la, lb);
    checks++;
    if ({sa, fa, la} !== {8'h2C, 2'b10, 32'sd1}) begin
      errors++;
      $display("FAIL w8d8_directed: got sum=%h c/o=%b lat=%0d required sum=2c c/o=10 lat=1", sa, fa, la);
    end
    checks++;
    if ({sb, fb, lb} !== {8'h2C, 2'b10, 32'sd8}) begin
      errors++;
      $display("FAIL w8d1_directed: got sum=%h c/o=%b lat=%0d required sum=2c c/o=10 lat=8", sb, fb, lb);
    end
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      model(8, longint'(a), longint'(b), cin, sub, es, eco, eov);
      op8(a, b, cin, sub, sa, sb, fa, fb, la, lb);
      checks++;
      if ({sa, fa, la, sb, fb, lb} !== {8'(es), eco, eov, 32'sd1, 8'(es), eco, eov, 32'sd8}) begin
        errors++;
        $display("FAIL w8_random[%0d] %h %s %h cin=%b: got d8=%h/%b/%0d d1=%h/%b/%0d required %h/%b%b lat 1 and 8",
                 i, a, sub ? "-" : "+", b, cin, sa, fa, la, sb, fb, lb, 8'(es), eco, eov);
      end
    end
    if8a.out_ready = 1'b0; if8b.out_ready = 1'b0;
  endtask

  initial begin
    if16.in_valid = 1'b0; if16.out_ready = 1'b0;
    if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.sub = 1'b0;
    if8a.in_valid = 1'b0; if8a.out_ready = 1'b0;
    if8a.a = '0; if8a.b = '0; if8a.cin = 1'b0; if8a.sub = 1'b0;
    if8b.in_valid = 1'b0; if8b.out_ready = 1'b0;
    if8b.a = '0; if8b.b = '0; if8b.cin = 1'b0; if8b.sub = 1'b0;
    test_reset();
    test_directed16();
    test_random16();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
